// File: rtl/sg_scheduler.sv
// ---------------------------------------------------------------------------
// sg_scheduler
//    Time-multiplexed sequencer for the spike-generator state memory. Each
//    time-unit pulse triggers a sweep over generators 0..gens_used-1. Each
//    enabled generator's ticks counter is decremented. A generator whose
//    ticks are already zero emits a 20-bit spike payload and reloads its
//    ticks with period-1. Host programming words are accepted only while
//    the sequencer is idle, so they never race the sweep.
//
// Ports
//    clk              single clock domain
//    reset            asynchronous, active-high
//    time_unit_pulse  one-cycle strobe starting a time unit
//    gens_used        number of generators swept
//    gens_en          per-generator enable mask
//    prog_valid/ready programming word handshake
//    prog_data        {sign, gen_idx[7:0], period, ticks, tag, unused[11:0]}
//    out_valid/ready  spike payload handshake
//    out_data         {sign, gen_idx[7:0], tag}
//    sweep_done       one-cycle pulse at the end of every sweep
//    overrun_count    saturating count of dropped time-unit pulses
// ---------------------------------------------------------------------------
module sg_scheduler #(
   parameter int NUM_GENS    = 16,
   parameter int PERIOD_BITS = 16,
   parameter int TAG_BITS    = 11
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                time_unit_pulse,
   input  logic [7:0]          gens_used,
   input  logic [NUM_GENS-1:0] gens_en,
   input  logic                prog_valid,
   output logic                prog_ready,
   input  logic [63:0]         prog_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [19:0]         out_data,
   output logic                sweep_done,
   output logic [15:0]         overrun_count
);

   localparam int             IDXW       = (NUM_GENS > 1) ? $clog2(NUM_GENS) : 1;
   localparam logic [8:0]     NUM_GENS_W = 9'(NUM_GENS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READ   = 2'd1,
      ST_UPDATE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Per-slot generator state
   logic                   sign_mem   [NUM_GENS];
   logic [PERIOD_BITS-1:0] period_mem [NUM_GENS];
   logic [PERIOD_BITS-1:0] ticks_mem  [NUM_GENS];
   logic [TAG_BITS-1:0]    tag_mem    [NUM_GENS];

   state_t                 state_r;
   logic [8:0]             idx_r;
   logic                   pending_r;

   // Slot latched in READ and worked on in UPDATE
   logic                   cur_sign_r;
   logic                   cur_en_r;
   logic [PERIOD_BITS-1:0] cur_period_r;
   logic [PERIOD_BITS-1:0] cur_ticks_r;
   logic [TAG_BITS-1:0]    cur_tag_r;

   // Programming word fields
   logic                   prog_sign_s;
   logic [7:0]             prog_gen_s;
   logic [PERIOD_BITS-1:0] prog_period_s;
   logic [PERIOD_BITS-1:0] prog_ticks_s;
   logic [TAG_BITS-1:0]    prog_tag_s;
   logic                   prog_in_range_s;
   logic                   unused_prog_bits_s;

   logic [8:0]             limit_s;
   logic [IDXW-1:0]        slot_s;
   logic [IDXW-1:0]        prog_slot_s;

   assign prog_sign_s        = prog_data[63];
   assign prog_gen_s         = prog_data[62:55];
   assign prog_period_s      = prog_data[39 +: PERIOD_BITS];
   assign prog_ticks_s       = prog_data[23 +: PERIOD_BITS];
   assign prog_tag_s         = prog_data[12 +: TAG_BITS];
   assign unused_prog_bits_s = ^prog_data[11:0];

   // Words addressed beyond the table are still handshaken, just not stored.
   assign prog_in_range_s = ({1'b0, prog_gen_s} < NUM_GENS_W);
   assign prog_slot_s     = prog_gen_s[IDXW-1:0];
   assign slot_s          = idx_r[IDXW-1:0];

   // Sweep length is clamped to the physical table size.
   assign limit_s = ({1'b0, gens_used} < NUM_GENS_W) ? {1'b0, gens_used} : NUM_GENS_W;

   // A pulse in the same cycle takes priority, so the word is held off rather
   // than racing the start of a sweep. Reset forces the handshake low.
   assign prog_ready = (state_r == ST_IDLE) && !pending_r && !time_unit_pulse && !reset;

   // Sequencer FSM, slot memory, pulse bookkeeping and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         idx_r         <= 9'd0;
         pending_r     <= 1'b0;
         cur_sign_r    <= 1'b0;
         cur_en_r      <= 1'b0;
         cur_period_r  <= {PERIOD_BITS{1'b0}};
         cur_ticks_r   <= {PERIOD_BITS{1'b0}};
         cur_tag_r     <= {TAG_BITS{1'b0}};
         out_valid     <= 1'b0;
         out_data      <= 20'h00000;
         sweep_done    <= 1'b0;
         overrun_count <= 16'h0000;
         for (int i = 0; i < NUM_GENS; i++) begin
            sign_mem[i]   <= 1'b0;
            period_mem[i] <= {PERIOD_BITS{1'b0}};
            ticks_mem[i]  <= {PERIOD_BITS{1'b0}};
            tag_mem[i]    <= {TAG_BITS{1'b0}};
         end
      end else begin
         // Pulses that land while a sweep is in flight: remember one, count the rest.
         if (time_unit_pulse && (state_r != ST_IDLE)) begin
            if (!pending_r) begin
               pending_r <= 1'b1;
            end else if (overrun_count != 16'hFFFF) begin
               overrun_count <= overrun_count + 16'd1;
            end else begin
               overrun_count <= overrun_count;
            end
         end

         case (state_r)
            ST_IDLE: begin
               if (time_unit_pulse || pending_r) begin
                  // A fresh pulse arriving while a remembered one is consumed stays pending.
                  idx_r     <= 9'd0;
                  pending_r <= pending_r & time_unit_pulse;
                  state_r   <= ST_READ;
               end else if (prog_valid && prog_ready) begin
                  if (prog_in_range_s) begin
                     sign_mem[prog_slot_s]   <= prog_sign_s;
                     period_mem[prog_slot_s] <= prog_period_s;
                     ticks_mem[prog_slot_s]  <= prog_ticks_s;
                     tag_mem[prog_slot_s]    <= prog_tag_s;
                  end
               end
            end

            ST_READ: begin
               if (idx_r >= limit_s) begin
                  sweep_done <= 1'b1;
                  state_r    <= ST_DONE;
               end else begin
                  cur_sign_r   <= sign_mem[slot_s];
                  cur_en_r     <= gens_en[slot_s];
                  cur_period_r <= period_mem[slot_s];
                  cur_ticks_r  <= ticks_mem[slot_s];
                  cur_tag_r    <= tag_mem[slot_s];
                  state_r      <= ST_UPDATE;
               end
            end

            ST_UPDATE: begin
               if (!cur_en_r || (cur_period_r == {PERIOD_BITS{1'b0}})) begin
                  idx_r   <= idx_r + 9'd1;
                  state_r <= ST_READ;
               end else if (cur_ticks_r != {PERIOD_BITS{1'b0}}) begin
                  ticks_mem[slot_s] <= cur_ticks_r - {{(PERIOD_BITS-1){1'b0}}, 1'b1};
                  idx_r             <= idx_r + 9'd1;
                  state_r           <= ST_READ;
               end else if (!out_valid) begin
                  // First UPDATE cycle of a firing slot presents the payload.
                  out_valid <= 1'b1;
                  out_data  <= {cur_sign_r, idx_r[7:0], cur_tag_r};
               end else if (out_ready) begin
                  out_valid         <= 1'b0;
                  ticks_mem[slot_s] <= cur_period_r - {{(PERIOD_BITS-1){1'b0}}, 1'b1};
                  idx_r             <= idx_r + 9'd1;
                  state_r           <= ST_READ;
               end else begin
                  out_valid <= out_valid;
               end
            end

            ST_DONE: begin
               sweep_done <= 1'b0;
               state_r    <= ST_IDLE;
            end

            default: begin
               sweep_done <= 1'b0;
               out_valid  <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sg_scheduler
//    Directed bench for sg_scheduler: reset values, period-1 firing, two
//    generators with different periods, enable masking, output backpressure,
//    pulse overrun and the gens_used=0 / out-of-range write / mid-sweep reset
//    corners. Expected payloads and latencies are hand-computed.
// ---------------------------------------------------------------------------
module tb_sg_scheduler;

   logic        clk;
   logic        reset;
   logic        time_unit_pulse;
   logic [7:0]  gens_used;
   logic [15:0] gens_en;
   logic        prog_valid;
   logic        prog_ready;
   logic [63:0] prog_data;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_data;
   logic        sweep_done;
   logic [15:0] overrun_count;

   int n_cmp;
   int n_err;

   logic [19:0] got_q[$];
   int          done_at;
   int          first_at;

   sg_scheduler #(.NUM_GENS(16), .PERIOD_BITS(16), .TAG_BITS(11)) dut (
      .clk            (clk),
      .reset          (reset),
      .time_unit_pulse(time_unit_pulse),
      .gens_used      (gens_used),
      .gens_en        (gens_en),
      .prog_valid     (prog_valid),
      .prog_ready     (prog_ready),
      .prog_data      (prog_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .sweep_done     (sweep_done),
      .overrun_count  (overrun_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic program_slot(input logic [7:0] gen, input logic sgn, input logic [15:0] per,
                               input logic [15:0] tk, input logic [10:0] tg);
      bit acc;
      acc        = 1'b0;
      prog_data  = {sgn, gen, per, tk, tg, 12'h000};
      prog_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (prog_ready) begin
            acc = 1'b1;
            tick();
            break;
         end
         tick();
      end
      prog_valid = 1'b0;
      n_cmp++;
      if (!acc) begin
         n_err++;
         $display("FAIL prog_accept gen=%0d: accepted=0 required=1", gen);
      end
   endtask

   // Pulse, then record every completed payload handshake until sweep_done.
   task automatic do_sweep(input int budget);
      got_q.delete();
      done_at         = -1;
      first_at        = -1;
      time_unit_pulse = 1'b1;
      tick();
      time_unit_pulse = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (first_at < 0) first_at = c;
         end
         if (sweep_done) begin
            done_at = c;
            break;
         end
         tick();
      end
      n_cmp++;
      if (done_at < 0) begin
         n_err++;
         $display("FAIL sweep_timeout: sweep_done=never required=within %0d cycles", budget);
      end
      repeat (3) tick();
   endtask

   task automatic wait_valid(input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL valid_timeout: out_valid=0 required=1 within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      n_cmp++;
      if (prog_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 20'h00000 ||
          sweep_done !== 1'b0 || overrun_count !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_values: ready=%b valid=%b data=%h done=%b ovr=%h required=0 0 00000 0 0000",
                  prog_ready, out_valid, out_data, sweep_done, overrun_count);
      end
      reset = 1'b0;
      #1;
      n_cmp++;
      if (prog_ready !== 1'b1) begin
         n_err++;
         $display("FAIL idle_ready: prog_ready=%b required=1", prog_ready);
      end
      tick();
   endtask

   task automatic test_period1();
      program_slot(8'd0, 1'b0, 16'd1, 16'd0, 11'd0);
      gens_used = 8'd1;
      gens_en   = 16'h0001;
      out_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         do_sweep(60);
         n_cmp++;
         if (got_q.size() != 1 || got_q[0] !== 20'h00000) begin
            n_err++;
            $display("FAIL p1_payload pulse%0d: count=%0d first=%h required=1 00000",
                     p, got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'hFFFFF);
         end
         n_cmp++;
         if (first_at < 1 || first_at > 3 || done_at != 5) begin
            n_err++;
            $display("FAIL p1_latency pulse%0d: out_at=%0d done_at=%0d required=<=3 5", p, first_at, done_at);
         end
         repeat (45) tick();
      end
   endtask

   task automatic test_two_gens();
      int exp_n;
      program_slot(8'd1, 1'b1, 16'd4, 16'd0, 11'd5);
      gens_used = 8'd2;
      gens_en   = 16'h0003;
      for (int p = 0; p < 9; p++) begin
         do_sweep(60);
         exp_n = ((p % 4) == 0) ? 2 : 1;
         n_cmp++;
         if (got_q.size() != exp_n) begin
            n_err++;
            $display("FAIL two_count pulse%0d: count=%0d required=%0d", p, got_q.size(), exp_n);
         end else begin
            n_cmp++;
            if (got_q[0] !== 20'h00000 || (exp_n == 2 && got_q[1] !== 20'h80805)) begin
               n_err++;
               $display("FAIL two_order pulse%0d: got=%h,%h required=00000,80805",
                        p, got_q[0], got_q[exp_n-1]);
            end
         end
         repeat (5) tick();
      end
   endtask

   task automatic test_enable_mask();
      // gen1 was left with ticks=3: fires on the 4th pulse from here.
      gens_en = 16'h0002;
      for (int p = 0; p < 4; p++) begin
         do_sweep(60);
         n_cmp++;
         if (p < 3) begin
            if (got_q.size() != 0) begin
               n_err++;
               $display("FAIL mask_quiet pulse%0d: count=%0d required=0", p, got_q.size());
            end
         end else begin
            if (got_q.size() != 1 || got_q[0] !== 20'h80805) begin
               n_err++;
               $display("FAIL mask_gen1: count=%0d first=%h required=1 80805",
                        got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'hFFFFF);
            end
         end
      end
      gens_en = 16'h0003;
      do_sweep(60);
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== 20'h00000) begin
         n_err++;
         $display("FAIL mask_reenable: count=%0d first=%h required=1 00000",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'hFFFFF);
      end
   endtask

   task automatic test_backpressure();
      int hs;
      int dn;
      gens_used       = 8'd1;
      gens_en         = 16'h0001;
      out_ready       = 1'b0;
      time_unit_pulse = 1'b1;
      tick();
      time_unit_pulse = 1'b0;
      wait_valid(10);
      prog_data  = {1'b1, 8'd2, 16'd1, 16'd0, 11'h02A, 12'h000};
      prog_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         n_cmp++;
         if (out_valid !== 1'b1 || out_data !== 20'h00000 || prog_ready !== 1'b0) begin
            n_err++;
            $display("FAIL stall_hold cyc%0d: valid=%b data=%h prog_ready=%b required=1 00000 0",
                     i, out_valid, out_data, prog_ready);
         end
         tick();
      end
      prog_valid = 1'b0;
      out_ready  = 1'b1;
      hs = 0;
      dn = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid && out_ready) hs++;
         if (sweep_done) dn++;
         tick();
      end
      n_cmp++;
      if (hs != 1 || dn != 1) begin
         n_err++;
         $display("FAIL stall_release: handshakes=%0d sweeps=%0d required=1 1", hs, dn);
      end
   endtask

   task automatic test_overrun();
      int hs;
      int dn;
      out_ready       = 1'b0;
      time_unit_pulse = 1'b1;
      tick();
      time_unit_pulse = 1'b0;
      wait_valid(10);
      for (int i = 0; i < 3; i++) begin
         time_unit_pulse = 1'b1;
         tick();
         time_unit_pulse = 1'b0;
         tick();
      end
      n_cmp++;
      if (overrun_count !== 16'd2) begin
         n_err++;
         $display("FAIL overrun_count: count=%0d required=2", overrun_count);
      end
      out_ready = 1'b1;
      hs = 0;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid && out_ready) hs++;
         if (sweep_done) dn++;
         tick();
      end
      n_cmp++;
      if (hs != 2 || dn != 2 || overrun_count !== 16'd2 || prog_ready !== 1'b1) begin
         n_err++;
         $display("FAIL overrun_resweep: handshakes=%0d sweeps=%0d ovr=%0d ready=%b required=2 2 2 1",
                  hs, dn, overrun_count, prog_ready);
      end
   endtask

   task automatic test_boundaries();
      gens_used = 8'd0;
      do_sweep(20);
      n_cmp++;
      if (got_q.size() != 0 || done_at != 2) begin
         n_err++;
         $display("FAIL zero_gens: count=%0d done_at=%0d required=0 2", got_q.size(), done_at);
      end

      // Slot 200 would alias onto slot 8 if truncated; a full sweep must show only gen0.
      program_slot(8'd200, 1'b1, 16'd1, 16'd0, 11'h033);
      gens_used = 8'd16;
      gens_en   = 16'hFFFF;
      do_sweep(100);
      n_cmp++;
      if (got_q.size() != 1 || got_q[0] !== 20'h00000 || done_at != 35) begin
         n_err++;
         $display("FAIL oob_write: count=%0d first=%h done_at=%0d required=1 00000 35",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 20'hFFFFF, done_at);
      end

      gens_used       = 8'd1;
      out_ready       = 1'b0;
      time_unit_pulse = 1'b1;
      tick();
      time_unit_pulse = 1'b0;
      wait_valid(10);
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || out_data !== 20'h00000 || overrun_count !== 16'h0000) begin
         n_err++;
         $display("FAIL reset_mid_update: valid=%b data=%h ovr=%0d required=0 00000 0",
                  out_valid, out_data, overrun_count);
      end
      tick();
      tick();
      reset     = 1'b0;
      out_ready = 1'b1;
      gens_used = 8'd2;
      gens_en   = 16'h0003;
      tick();
      do_sweep(30);
      n_cmp++;
      if (got_q.size() != 0 || done_at != 6) begin
         n_err++;
         $display("FAIL post_reset_sweep: count=%0d done_at=%0d required=0 6", got_q.size(), done_at);
      end
   endtask

   initial begin
      n_cmp           = 0;
      n_err           = 0;
      reset           = 1'b1;
      time_unit_pulse = 1'b0;
      gens_used       = 8'd0;
      gens_en         = 16'h0000;
      prog_valid      = 1'b0;
      prog_data       = 64'h0;
      out_ready       = 1'b1;

      test_reset();
      test_period1();
      test_two_gens();
      test_enable_mask();
      test_backpressure();
      test_overrun();
      test_boundaries();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sg_scheduler.md
Name: sg_scheduler

Overview:
- Time-multiplexed sequencer for the spike-generator (SG) state memory.
- On each time-unit pulse it sweeps generators 0..gens_used-1, counts down each enabled generator's ticks, and emits a 20-bit BD spike payload when a generator fires.
- Also arbitrates host programming writes (64-bit SG words assembled from the endpoint-112 pieces) against the sweep; it sits between the host register/channel decoder and the BD downstream horn.

Parameters:
- NUM_GENS, 16, number of generator slots; must be ≤ 256.
- PERIOD_BITS, 16, width of the period and ticks fields.
- TAG_BITS, 11, width of the tag field.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  asynchronous, active-high.
- time_unit_pulse  input  1  one-cycle strobe marking the start of a time unit.
- gens_used  input  8  number of generators swept (register 69).
- gens_en  input  NUM_GENS  per-generator enable mask (register 70).
- prog_valid  input  1  programming word valid.
- prog_ready  output  1  programming word accepted when high with prog_valid.
- prog_data  input  64  {sign[63], gen_idx[62:55], period[54:39], ticks[38:23], tag[22:12], unused[11:0]}.
- out_valid  output  1  spike payload valid.
- out_ready  input  1  downstream ready.
- out_data  output  20  {sign, gen_idx[7:0], tag[10:0]}.
- sweep_done  output  1  one-cycle pulse when a sweep completes.
- overrun_count  output  16  saturating count of dropped time-unit pulses.

Behaviour:
- Reset values: prog_ready=0, out_valid=0, out_data=0, sweep_done=0, overrun_count=0, pending=0, FSM=IDLE, all memory entries cleared (period=0, so no generator fires).
- Per-slot state: sign, period, ticks, tag.
- FSM states: IDLE, READ, UPDATE, DONE.
- IDLE:
  - prog_ready=1 iff pending=0 and time_unit_pulse=0.
  - A prog handshake writes slot gen_idx in that cycle. Writes with gen_idx ≥ NUM_GENS are accepted and discarded.
  - A time_unit_pulse or pending=1 sets idx=0, clears pending, and goes to READ. The pulse wins over a concurrent prog_valid; the word waits.
- READ:
  - If idx ≥ min(gens_used, NUM_GENS), go to DONE.
  - Otherwise latch slot idx and go to UPDATE.
- UPDATE:
  - Disabled slot or period==0: no write; idx++; go to READ.
  - ticks≠0: write ticks-1; idx++; go to READ.
  - ticks==0: assert out_valid with out_data={sign, idx, tag}. Hold out_valid and out_data stable until out_ready. On the handshake, write ticks=period-1, idx++, go to READ.
- Timing: 2 cycles per non-firing generator; firing adds backpressure cycles.
- DONE: sweep_done=1 for one cycle, then go to IDLE.
- gens_used=0: IDLE→READ→DONE with no output.
- Time-unit pulses outside IDLE:
  - If pending=0, set pending=1.
  - If pending=1, increment overrun_count (saturates at 0xFFFF).
  - A pulse arriving in the same cycle as DONE sets pending.
- Sign is carried through unmodified.
- period=1 fires every time unit; period=P with initial ticks=T fires at time units T, T+P, T+2P, … (0-based).
- Reset mid-sweep or mid-backpressure returns everything to reset values immediately. A partially written slot is not preserved.

Test Plan:
- Firing at period 1: program gen0 {sign0, idx0, period1, ticks0, tag0}; gens_used=1, gens_en=1; 3 pulses spaced 50 cycles → 3 outputs of 0x00000, each within 3 cycles of its pulse; sweep_done after each.
- Two generators: add gen1 {sign1, idx1, period4, ticks0, tag5}; gens_used=2, gens_en=3; 9 pulses → gen0 fires at every pulse. gen1 emits 0x80805 (sign1, idx1, tag5) at pulses 0, 4, 8 only, always after gen0's payload within a time unit.
- Enable mask: gens_en=2 with the same programming → only gen1 outputs. gen0's ticks are untouched: after re-enabling it fires on the next pulse.
- Backpressure: hold out_ready=0 for 20 cycles while gen0 fires → out_valid and out_data stay stable; no prog handshake completes during the stall. Release → exactly one handshake.
- Overrun: keep out_ready=0 and issue 3 extra pulses → pending=1 and overrun_count=2. Release → a second sweep runs immediately.
- Boundaries:
  - gens_used=0 → no output; sweep_done 2 cycles after the pulse.
  - Write to gen_idx=200 → accepted, no effect.
  - Assert reset during UPDATE → out_valid=0 the same cycle; memory is cleared, so the next sweep emits nothing.
